// File: rtl/aes_key_schedule_if.sv
// Key-load / round-key-read bus for aes_key_schedule.
// The master is the key source plus the round datapath; the slave is the key schedule.
interface aes_key_schedule_if #(
  parameter int KEY_BITS = 128
);
  logic [KEY_BITS-1:0] key_in;
  logic                key_valid;
  logic                key_ready;
  logic [3:0]          round;
  logic [127:0]        rk_out;
  logic                rk_valid;
  logic                busy;
  logic                done;

  modport master (
    output key_in, key_valid, round,
    input  key_ready, rk_out, rk_valid, busy, done
  );

  modport slave (
    input  key_in, key_valid, round,
    output key_ready, rk_out, rk_valid, busy, done
  );
endinterface

// File: rtl/aes_key_schedule.sv
// Runtime AES-128/192/256 key expansion (one word per clock) into a round-key table.
// Optional macro AES_KEY_SCHEDULE_ZEROIZE_EN adds a zeroize input that wipes all key material.
module aes_key_schedule #(
  parameter int KEY_BITS = 128
) (
  input  logic clk,
  input  logic rst_n,
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
  input  logic zeroize,
`endif
  aes_key_schedule_if.slave bus
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [5:0] NK6     = 6'(NK);
  localparam logic [5:0] LAST_W  = 6'(NW - 1);
  localparam logic [2:0] KM_LAST = 3'(NK - 1);
  localparam logic [3:0] NR4     = 4'(NR);

  generate
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t      state;
  logic [31:0] w [NW];
  logic [5:0]  i;
  logic [2:0]  kmod;   // i mod NK, kept alongside i to avoid a divider
  logic [7:0]  rcon;
  logic        tbl_ok;

  logic [31:0] prev, t, w_new;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    prev = w[i - 6'd1];
    t    = prev;
    if (kmod == 3'd0)
      t = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0};
    else if (NK == 8 && kmod == 3'd4)
      t = sub_word(prev);
    w_new = w[i - NK6] ^ t;
  end

  // NOTE: sequential state uses non-blocking assignments only; the table is a plain
  // register array, so it can be reset like any other flop and key material never survives rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      for (int k = 0; k < NW; k++) w[k] <= '0;
      i             <= '0;
      kmod          <= '0;
      rcon          <= 8'h01;
      tbl_ok        <= 1'b0;
      bus.key_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.rk_out    <= '0;
      bus.rk_valid  <= 1'b0;
    end else begin
      bus.done <= 1'b0;

      if (tbl_ok && bus.round <= NR4) begin
        bus.rk_out   <= {w[{bus.round, 2'b00}], w[{bus.round, 2'b01}],
                         w[{bus.round, 2'b10}], w[{bus.round, 2'b11}]};
        bus.rk_valid <= 1'b1;
      end else begin
        bus.rk_out   <= '0;
        bus.rk_valid <= 1'b0;
      end

`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
      if (zeroize) begin
        state         <= IDLE;
        for (int k = 0; k < NW; k++) w[k] <= '0;
        i             <= '0;
        kmod          <= '0;
        rcon          <= 8'h01;
        tbl_ok        <= 1'b0;
        bus.key_ready <= 1'b1;
        bus.busy      <= 1'b0;
        bus.rk_out    <= '0;
        bus.rk_valid  <= 1'b0;
      end else
`endif
      begin
        unique case (state)
          IDLE, READY: begin
            if (bus.key_valid && bus.key_ready) begin
              for (int k = 0; k < NK; k++) w[k] <= bus.key_in[KEY_BITS-1-32*k -: 32];
              i             <= NK6;
              kmod          <= '0;
              rcon          <= 8'h01;
              tbl_ok        <= 1'b0;
              bus.busy      <= 1'b1;
              bus.key_ready <= 1'b0;
              state         <= EXPAND;
            end
          end
          EXPAND: begin
            w[i] <= w_new;
            i    <= i + 6'd1;
            kmod <= (kmod == KM_LAST) ? 3'd0 : kmod + 3'd1;
            if (kmod == 3'd0) rcon <= xtime(rcon);
            if (i == LAST_W) begin
              state         <= READY;
              tbl_ok        <= 1'b1;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
              bus.key_ready <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
